// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, variable-latency imem handshake, F/D register.
// Optional address-error check enabled by defining FETCH_ADEL_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_i,
    input  logic        stall_i,
    input  logic        int_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic        d_is_branch_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic        fetch_busy_o,
    output logic [31:0] d_instr_o,
    output logic [31:0] d_pc_o,
    output logic [4:0]  d_exccode_o,
    output logic        d_bd_o,
    output logic        d_valid_o
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HELD} state_t;

    localparam logic [4:0] EXC_ADEL = 5'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold;
    logic [4:0]  r_holdExc;
    logic [31:0] r_dInstr;
    logic [31:0] r_dPc;
    logic [4:0]  r_dExc;
    logic        r_dBd;
    logic        r_dValid;

    logic        w_flush;
    logic [31:0] w_redirect;
    logic        w_active;
    logic        w_adel;
    logic        w_complete;
    logic [31:0] w_fetchWord;
    logic [4:0]  w_fetchExc;

`ifdef FETCH_ADEL_EN
    assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);
`else
    assign w_adel = 1'b0;
`endif

    assign w_flush     = int_req_i | eret_i;
    assign w_redirect  = int_req_i ? EXC_ENTRY : epc_i;
    assign w_active    = (r_state != S_HELD);
    // A bad address completes at once as a nop, so it never waits on memory.
    assign w_complete  = w_active & (w_adel | imem_ready_i);
    assign w_fetchWord = w_adel ? 32'h0 : imem_rdata_i;
    assign w_fetchExc  = w_adel ? EXC_ADEL : 5'd0;

    assign imem_req_o   = rst_n & w_active & ~w_flush & ~w_adel;
    assign imem_addr_o  = r_pc;
    assign fetch_busy_o = imem_req_o & ~imem_ready_i;
    assign pc_o         = r_pc;
    assign d_instr_o    = r_dInstr;
    assign d_pc_o       = r_dPc;
    assign d_exccode_o  = r_dExc;
    assign d_bd_o       = r_dBd;
    assign d_valid_o    = r_dValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_hold    <= 32'h0;
            r_holdExc <= 5'd0;
            r_dInstr  <= 32'h0;
            r_dPc     <= 32'h0;
            r_dExc    <= 5'd0;
            r_dBd     <= 1'b0;
            r_dValid  <= 1'b0;
        end else if (w_flush) begin
            r_state   <= S_FETCH;
            r_pc      <= w_redirect;
            r_hold    <= 32'h0;
            r_holdExc <= 5'd0;
            r_dInstr  <= 32'h0;
            r_dPc     <= 32'h0;
            r_dExc    <= 5'd0;
            r_dBd     <= 1'b0;
            r_dValid  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH, S_WAIT: begin
                    if (w_complete) begin
                        if (!stall_i) begin
                            r_dInstr <= w_fetchWord;
                            r_dPc    <= r_pc;
                            r_dExc   <= w_fetchExc;
                            r_dBd    <= d_is_branch_i;
                            r_dValid <= 1'b1;
                            r_pc     <= npc_i;
                            r_state  <= S_FETCH;
                        end else begin
                            r_hold    <= w_fetchWord;
                            r_holdExc <= w_fetchExc;
                            r_state   <= S_HELD;
                        end
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_HELD: begin
                    if (!stall_i) begin
                        r_dInstr <= r_hold;
                        r_dPc    <= r_pc;
                        r_dExc   <= r_holdExc;
                        r_dBd    <= d_is_branch_i;
                        r_dValid <= 1'b1;
                        r_pc     <= npc_i;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage; expectations follow FETCH_ADEL_EN if defined.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        int_req_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [31:0] epc_i = 32'h0;
    logic        d_is_branch_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_ready_i = 1'b0;
    logic [31:0] pc_o;
    logic        fetch_busy_o;
    logic [31:0] d_instr_o;
    logic [31:0] d_pc_o;
    logic [4:0]  d_exccode_o;
    logic        d_bd_o;
    logic        d_valid_o;

    int total = 0;
    int bad = 0;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .npc_i(npc_i), .stall_i(stall_i),
        .int_req_i(int_req_i), .eret_i(eret_i), .epc_i(epc_i),
        .d_is_branch_i(d_is_branch_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .imem_ready_i(imem_ready_i), .pc_o(pc_o), .fetch_busy_o(fetch_busy_o),
        .d_instr_o(d_instr_o), .d_pc_o(d_pc_o), .d_exccode_o(d_exccode_o),
        .d_bd_o(d_bd_o), .d_valid_o(d_valid_o)
    );

    always #5 clk = ~clk;

    // Inputs are driven after the falling edge; expected outputs are those seen
    // just before the following rising edge.
    typedef struct {
        logic        stall, intr, eret, br, ready;
        logic [31:0] epc, npc, rdata;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eBusy;
        logic [31:0] ePc, eInstr, eDpc;
        logic [4:0]  eExc;
        logic        eBd, eValid;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s vec=%0d actual=%h required=%h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stall_i       = v.stall;
        int_req_i     = v.intr;
        eret_i        = v.eret;
        d_is_branch_i = v.br;
        imem_ready_i  = v.ready;
        epc_i         = v.epc;
        npc_i         = v.npc;
        imem_rdata_i  = v.rdata;
    endtask

    initial begin
        //           st int er br rdy epc           npc           rdata          req addr          bsy pc            instr         dpc           exc   bd vld
        vecs[0]  = '{0, 0, 0, 0, 1, 32'h0,        32'h3004,     32'hA000_0001, 1, 32'h3000,     0, 32'h3000,     32'h0,        32'h0,        5'd0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,        32'h3008,     32'h0,         1, 32'h3004,     1, 32'h3004,     32'hA000_0001, 32'h3000,    5'd0, 0, 1};
        vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,        32'h3008,     32'h0,         1, 32'h3004,     1, 32'h3004,     32'hA000_0001, 32'h3000,    5'd0, 0, 1};
        vecs[3]  = '{0, 0, 0, 0, 0, 32'h0,        32'h3008,     32'h0,         1, 32'h3004,     1, 32'h3004,     32'hA000_0001, 32'h3000,    5'd0, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 1, 32'h0,        32'h3008,     32'hA000_0002, 1, 32'h3004,     0, 32'h3004,     32'hA000_0001, 32'h3000,    5'd0, 0, 1};
        vecs[5]  = '{1, 0, 0, 0, 1, 32'h0,        32'h300C,     32'hA000_0003, 1, 32'h3008,     0, 32'h3008,     32'hA000_0002, 32'h3004,    5'd0, 0, 1};
        vecs[6]  = '{1, 0, 0, 0, 1, 32'h0,        32'h300C,     32'hDEAD_BEEF, 0, 32'h3008,     0, 32'h3008,     32'hA000_0002, 32'h3004,    5'd0, 0, 1};
        vecs[7]  = '{0, 0, 0, 1, 1, 32'h0,        32'h300C,     32'hDEAD_BEEF, 0, 32'h3008,     0, 32'h3008,     32'hA000_0002, 32'h3004,    5'd0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 1, 32'h0,        32'h3010,     32'hA000_0004, 1, 32'h300C,     0, 32'h300C,     32'hA000_0003, 32'h3008,    5'd0, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 32'h0,        32'h3014,     32'h0,         1, 32'h3010,     1, 32'h3010,     32'hA000_0004, 32'h300C,    5'd0, 0, 1};
        vecs[10] = '{1, 1, 0, 0, 1, 32'h0,        32'h3014,     32'hBADB_AD00, 0, 32'h3010,     0, 32'h3010,     32'hA000_0004, 32'h300C,    5'd0, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 32'h0,        32'h4184,     32'h0,         1, 32'h4180,     1, 32'h4180,     32'h0,        32'h0,        5'd0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 1, 32'h0,        32'h4184,     32'hA000_0005, 1, 32'h4180,     0, 32'h4180,     32'h0,        32'h0,        5'd0, 0, 0};
        vecs[13] = '{0, 0, 1, 0, 1, 32'h3020,     32'h4188,     32'h1111_1111, 0, 32'h4184,     0, 32'h4184,     32'hA000_0005, 32'h4180,    5'd0, 0, 1};
        vecs[14] = '{0, 0, 0, 0, 1, 32'h0,        32'h3002,     32'hA000_0006, 1, 32'h3020,     0, 32'h3020,     32'h0,        32'h0,        5'd0, 0, 0};
`ifdef FETCH_ADEL_EN
        vecs[15] = '{0, 0, 0, 0, 1, 32'h0,        32'h3008,     32'hA000_0007, 0, 32'h3002,     0, 32'h3002,     32'hA000_0006, 32'h3020,    5'd0, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 1, 32'h0,        32'h300C,     32'hA000_0008, 1, 32'h3008,     0, 32'h3008,     32'h0,        32'h3002,     5'd4, 0, 1};
`else
        vecs[15] = '{0, 0, 0, 0, 1, 32'h0,        32'h3008,     32'hA000_0007, 1, 32'h3002,     0, 32'h3002,     32'hA000_0006, 32'h3020,    5'd0, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 1, 32'h0,        32'h300C,     32'hA000_0008, 1, 32'h3008,     0, 32'h3008,     32'hA000_0007, 32'h3002,    5'd0, 0, 1};
`endif

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req",   -1, {31'h0, imem_req_o}, 32'h0);
        checkOutput("rst_pc",    -1, pc_o, 32'h3000);
        checkOutput("rst_instr", -1, d_instr_o, 32'h0);
        checkOutput("rst_dpc",   -1, d_pc_o, 32'h0);
        checkOutput("rst_valid", -1, {31'h0, d_valid_o}, 32'h0);
        checkOutput("rst_bd",    -1, {31'h0, d_bd_o}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput("req",   i, {31'h0, imem_req_o}, {31'h0, vecs[i].eReq});
            checkOutput("addr",  i, imem_addr_o, vecs[i].eAddr);
            checkOutput("busy",  i, {31'h0, fetch_busy_o}, {31'h0, vecs[i].eBusy});
            checkOutput("pc",    i, pc_o, vecs[i].ePc);
            checkOutput("instr", i, d_instr_o, vecs[i].eInstr);
            checkOutput("dpc",   i, d_pc_o, vecs[i].eDpc);
            checkOutput("exc",   i, {27'h0, d_exccode_o}, {27'h0, vecs[i].eExc});
            checkOutput("bd",    i, {31'h0, d_bd_o}, {31'h0, vecs[i].eBd});
            checkOutput("valid", i, {31'h0, d_valid_o}, {31'h0, vecs[i].eValid});
        end

        // Async reset mid-run returns everything to the reset state without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_pc",    -2, pc_o, 32'h3000);
        checkOutput("arst_valid", -2, {31'h0, d_valid_o}, 32'h0);
        checkOutput("arst_req",   -2, {31'h0, imem_req_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the next-PC logic and the D stage.
- Holds the architectural fetch PC.
- Issues instruction-memory requests with variable-latency handshake.
- Captures the returned word into the F/D pipeline register.
- Consumes the next-PC value from the next-PC unit, plus interrupt and eret redirects from CP0.
- Tags each fetched instruction with delay-slot and address-error status.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
EXC_ENTRY, 32'h0000_4180, exception handler entry address
TEXT_LO, 32'h0000_3000, lowest legal fetch address (inclusive)
TEXT_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
npc_i  in  32  next PC from the next-PC unit
stall_i  in  1  hazard-unit stall; freezes PC and F/D
int_req_i  in  1  CP0 interrupt/exception request
eret_i  in  1  eret in D; redirect to epc_i
epc_i  in  32  CP0 EPC
d_is_branch_i  in  1  instruction currently in D is a branch/jump
imem_req_o  out  1  instruction-memory request
imem_addr_o  out  32  request address (= pc_o while requesting)
imem_rdata_i  in  32  returned instruction word
imem_ready_i  in  1  rdata valid this cycle; completes the request
pc_o  out  32  current fetch PC
fetch_busy_o  out  1  request outstanding and not yet ready; hazard unit ORs into stall
d_instr_o  out  32  F/D instruction
d_pc_o  out  32  F/D PC
d_exccode_o  out  5  F/D exception code (0 = none, 4 = AdEL)
d_bd_o  out  1  F/D instruction is in a branch delay slot
d_valid_o  out  1  F/D holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_PC; state=FETCH; hold register cleared.
  - d_instr_o=0, d_pc_o=0, d_exccode_o=0, d_bd_o=0, d_valid_o=0.
  - imem_req_o=0 while in reset.
- FSM states:
  - FETCH: imem_req_o=1, addr=pc_o.
    - imem_ready_i=1 and stall_i=0: word goes into F/D; PC advances; stay in FETCH.
    - imem_ready_i=1 and stall_i=1: word goes into the hold register; go to HELD.
    - imem_ready_i=0: go to WAIT.
  - WAIT: req and addr held stable.
    - ready=1 completes exactly as in FETCH (to F/D or HELD).
  - HELD: imem_req_o=0.
    - When stall_i falls, the hold register goes into F/D, PC advances, and the FSM returns to FETCH.
- fetch_busy_o = imem_req_o & ~imem_ready_i.
- PC advance (only on completion with no stall), priority order:
  1. int_req_i → EXC_ENTRY
  2. eret_i → epc_i
  3. otherwise npc_i
- Flush:
  - Any cycle with int_req_i=1, regardless of stall_i or state: F/D cleared (d_valid_o=0, d_instr_o=0, d_exccode_o=0, d_bd_o=0).
  - On the same cycle: hold register dropped, pc_o←EXC_ENTRY, FSM→FETCH, imem_req_o deasserted.
  - A coincident imem_ready_i is ignored.
  - Memory must accept request abandonment.
- eret_i=1 (no int_req_i): same flush and abort, with pc_o←epc_i. eret has no delay slot.
- F/D load: d_pc_o=PC of the fetched word, d_valid_o=1, d_bd_o=d_is_branch_i sampled on the load edge.
- stall_i=1 with no flush: PC and F/D hold their values.
- Address check (see Optional Feature): if pc_o[1:0]≠0 or pc_o is outside [TEXT_LO, TEXT_HI]:
  - No request is issued.
  - Fetch completes immediately with instr=0 (nop) and exccode=4.
- PC arithmetic is 32-bit wrap; no saturation.

Optional Feature:
FETCH_ADEL_EN
- Defined: the address check above is active.
- Undefined: no check; every PC issues a request and d_exccode_o is constant 0.

Test Plan:
- Reset release, imem_ready_i tied 1, npc_i=pc+4 → fetches at 0x3000, 0x3004, 0x3008; d_pc_o lags pc_o by one cycle; d_valid_o=1 from the second edge.
- ready delayed 3 cycles at 0x3004 → imem_addr_o stable at 0x3004 for 4 cycles; fetch_busy_o=1 for 3 cycles; d_instr_o updates once.
- stall_i high 2 cycles while ready returns → FSM enters HELD; imem_req_o=0; after stall falls, F/D gets the held word and no duplicate request is issued.
- int_req_i pulse during WAIT with stall_i=1 → next cycle pc_o=0x4180, d_valid_o=0, first request at 0x4180.
- Branch in D (d_is_branch_i=1) at the load edge → the next F/D load has d_bd_o=1; the following load has d_bd_o=0.
- npc_i=0x3002 with FETCH_ADEL_EN → no imem_req_o; d_instr_o=0 and d_exccode_o=4. Without the macro → request issued at 0x3002 and d_exccode_o=0.
